reg_arb: RTL

Two-port access arbiter for the CPU register file. It shares the register file's single select/write port between requester A (core datapath) and requester B (debug/loader), grants one access per cycle, and returns registered read data with a per-requester valid strobe. It sits between the requesters and the register file. It drives the file's SEL/IN/EN and consumes its registered OUT.

---
 rtl/reg_arb.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/reg_arb.sv
// Two-port arbiter sharing the register file select/write port between A and B.
// Optional lock/burst ownership enabled by defining REG_ARB_LOCK_EN.
module reg_arb #(
    parameter int WIDTH     = 8,
    parameter int SIZE      = 9,
    parameter int AW        = $clog2(SIZE),
    parameter int MAX_BURST = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             A_REQ,
    input  logic             B_REQ,
    input  logic             A_WE,
    input  logic             B_WE,
    input  logic             A_LOCK,
    input  logic             B_LOCK,
    input  logic [AW-1:0]    A_ADDR,
    input  logic [AW-1:0]    B_ADDR,
    input  logic [WIDTH-1:0] A_WDATA,
    input  logic [WIDTH-1:0] B_WDATA,
    output logic             A_GNT,
    output logic             B_GNT,
    output logic             A_RVALID,
    output logic             B_RVALID,
    output logic [WIDTH-1:0] RDATA,
    output logic [AW-1:0]    RF_SEL,
    output logic [WIDTH-1:0] RF_IN,
    output logic             RF_EN,
    input  logic [WIDTH-1:0] RF_OUT
);

    logic last_b;
    logic gnt_a;
    logic gnt_b;

    // SIZE-1 is the read-only port-input register; all-ones is the port output.
    function automatic logic writable(input logic [AW-1:0] addr);
        return (addr <= AW'(SIZE - 2)) || (addr == {AW{1'b1}});
    endfunction

`ifdef REG_ARB_LOCK_EN
    // state | meaning
    // IDLE  | per-cycle arbitration, tie goes to the requester that was not LAST
    // OWN_A | A holds the port while A_REQ & A_LOCK, up to MAX_BURST grants
    // OWN_B | B holds the port while B_REQ & B_LOCK, up to MAX_BURST grants
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    localparam int CW = $clog2(MAX_BURST + 1);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gnt_a   = 1'b0;
        gnt_b   = 1'b0;
        case (state_q)
            IDLE: begin
                if (A_REQ && (!B_REQ || last_b)) begin
                    gnt_a = 1'b1;
                end else if (B_REQ) begin
                    gnt_b = 1'b1;
                end
                // A one-grant burst is already complete, so no ownership is taken.
                if (MAX_BURST > 1) begin
                    if (gnt_a && A_LOCK) begin
                        state_d = OWN_A;
                        cnt_d   = CW'(1);
                    end else if (gnt_b && B_LOCK) begin
                        state_d = OWN_B;
                        cnt_d   = CW'(1);
                    end
                end
            end
            OWN_A: begin
                if (A_REQ && A_LOCK) begin
                    gnt_a = 1'b1;
                    if (cnt_q == CW'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            OWN_B: begin
                if (B_REQ && B_LOCK) begin
                    gnt_b = 1'b1;
                    if (cnt_q == CW'(MAX_BURST - 1)) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end
`else
    logic                 unused_lock;
    localparam int        unused_max_burst = MAX_BURST;

    assign unused_lock = A_LOCK ^ B_LOCK;

    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (A_REQ && (!B_REQ || last_b)) begin
            gnt_a = 1'b1;
        end else if (B_REQ) begin
            gnt_b = 1'b1;
        end
    end
`endif

    // Grants are forced low while reset is asserted, not just after the next edge.
    assign A_GNT = gnt_a & RST_N;
    assign B_GNT = gnt_b & RST_N;

    always_comb begin
        RF_SEL = '0;
        RF_IN  = '0;
        RF_EN  = 1'b0;
        if (A_GNT) begin
            RF_SEL = A_ADDR;
            RF_IN  = A_WDATA;
            RF_EN  = A_WE & writable(A_ADDR);
        end else if (B_GNT) begin
            RF_SEL = B_ADDR;
            RF_IN  = B_WDATA;
            RF_EN  = B_WE & writable(B_ADDR);
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_b   <= 1'b1;
            A_RVALID <= 1'b0;
            B_RVALID <= 1'b0;
        end else begin
            if (A_GNT) begin
                last_b <= 1'b0;
            end else if (B_GNT) begin
                last_b <= 1'b1;
            end
            A_RVALID <= A_GNT & ~A_WE;
            B_RVALID <= B_GNT & ~B_WE;
        end
    end

    // The register file output is already registered; only qualify it here.
    assign RDATA = (A_RVALID || B_RVALID) ? RF_OUT : '0;

endmodule
